// File: rtl/odd_parity_tx_ctrl_pkg.sv
// odd_parity_pkg: shared FSM states, widths and reset constants
package odd_parity_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
  localparam int FRAME_CNT_W = 16;
  localparam logic PARITY_INIT = 1'b1;
endpackage

// File: rtl/odd_parity_tx_ctrl_if.sv
// odd_parity_tx_ctrl_if: word handshake and serial frame signals
// err_inject exists only when PARITY_ERR_INJECT_EN is defined.
interface odd_parity_tx_ctrl_if import odd_parity_pkg::*; #(parameter int DATA_W = 8);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic ser_out;
  logic ser_valid;
  logic frame_start;
  logic frame_done;
  logic busy;
  logic [FRAME_CNT_W-1:0] frame_cnt;
`ifdef PARITY_ERR_INJECT_EN
  logic err_inject;
  modport master (output in_valid, in_data, err_inject,
                  input in_ready, ser_out, ser_valid, frame_start, frame_done, busy, frame_cnt);
  modport slave (input in_valid, in_data, err_inject,
                 output in_ready, ser_out, ser_valid, frame_start, frame_done, busy, frame_cnt);
`else
  modport master (output in_valid, in_data,
                  input in_ready, ser_out, ser_valid, frame_start, frame_done, busy, frame_cnt);
  modport slave (input in_valid, in_data,
                 output in_ready, ser_out, ser_valid, frame_start, frame_done, busy, frame_cnt);
`endif
endinterface

// File: rtl/odd_parity_tx_ctrl_acc.sv
// odd_parity_acc: running odd-parity accumulator, one bit per enabled cycle
module odd_parity_acc import odd_parity_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic bit_en,
  input  logic bit_in,
  output logic par
);
  always_ff @(posedge clk or posedge rst)
    if (rst) par <= PARITY_INIT;
    else if (init) par <= PARITY_INIT;
    else if (bit_en) par <= par ^ bit_in;
endmodule

// File: rtl/odd_parity_tx_ctrl.sv
// odd_parity_tx_ctrl: serialises words LSB first plus odd parity; PARITY_ERR_INJECT_EN adds err_inject
module odd_parity_tx_ctrl import odd_parity_pkg::*; #(parameter int DATA_W = 8) (
  input logic clk,
  input logic rst,
  odd_parity_tx_ctrl_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  state_t state, state_nx;
  logic [DATA_W-1:0] sh;
  logic [CW-1:0] cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic ser_out, ser_valid, frame_start, frame_done;
  logic par, inj, take, last, in_data_st;
  assign bus.in_ready = state != DATA;
  assign bus.busy = state != IDLE;
  assign bus.ser_out = ser_out;
  assign bus.ser_valid = ser_valid;
  assign bus.frame_start = frame_start;
  assign bus.frame_done = frame_done;
  assign bus.frame_cnt = frame_cnt;
  assign take = bus.in_valid && bus.in_ready;
  assign last = cnt == CW'(DATA_W - 1);
  assign in_data_st = state == DATA;
  always_comb state_nx = take ? DATA : (in_data_st && !last) ? DATA : in_data_st ? PARITY : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // the accumulator still lacks the bit on ser_out when the parity is registered
  odd_parity_acc u_acc (.clk(clk), .rst(rst), .init(take), .bit_en(in_data_st), .bit_in(ser_out), .par(par));
`ifdef PARITY_ERR_INJECT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) inj <= 1'b0;
    else if (take) inj <= bus.err_inject;
    else if (state == PARITY) inj <= 1'b0;
`else
  assign inj = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh <= '0;
      cnt <= '0;
      ser_out <= 1'b0;
      ser_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_start <= take;
      frame_done <= in_data_st && last;
      ser_valid <= take || in_data_st;
      if (take) begin
        sh <= bus.in_data >> 1;
        cnt <= '0;
        ser_out <= bus.in_data[0];
      end else if (in_data_st) begin
        sh <= sh >> 1;
        cnt <= cnt + CW'(1);
        ser_out <= last ? par ^ ser_out ^ inj : sh[0];
      end else ser_out <= 1'b0;
      if (state == PARITY) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
endmodule

// File: tb/tb_odd_parity_tx_ctrl.sv
// tb_odd_parity_tx_ctrl: stream-model checker for DATA_W=8 and DATA_W=3 instances
module tb_odd_parity_tx_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  odd_parity_tx_ctrl_if #(.DATA_W(8)) bus8();
  odd_parity_tx_ctrl_if #(.DATA_W(3)) bus3();
  odd_parity_tx_ctrl #(.DATA_W(8)) u8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  odd_parity_tx_ctrl #(.DATA_W(3)) u3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: queue of per-cycle frame entries {valid, bit, start, done}
  logic [3:0] q8[$], q3[$];
  logic [3:0] cur8 = '0, cur3 = '0;
  logic [15:0] cnt8 = '0, cnt3 = '0;
  logic par8[$], par3[$];
  logic e8, e3;

  always @(posedge clk or posedge rst)
    if (rst) begin
      q8.delete();
      cur8 = '0;
      cnt8 = '0;
    end else begin
      if (cur8[0]) cnt8 = cnt8 + 16'd1;
      if (bus8.in_valid && q8.size() == 0) begin
`ifdef PARITY_ERR_INJECT_EN
        e8 = bus8.err_inject;
`else
        e8 = 1'b0;
`endif
        for (int i = 0; i < 8; i++) q8.push_back({1'b1, bus8.in_data[i], i == 0, 1'b0});
        q8.push_back({1'b1, ~^bus8.in_data ^ e8, 1'b0, 1'b1});
      end
      cur8 = q8.size() != 0 ? q8.pop_front() : 4'b0;
    end

  always @(posedge clk or posedge rst)
    if (rst) begin
      q3.delete();
      cur3 = '0;
      cnt3 = '0;
    end else begin
      if (cur3[0]) cnt3 = cnt3 + 16'd1;
      if (bus3.in_valid && q3.size() == 0) begin
`ifdef PARITY_ERR_INJECT_EN
        e3 = bus3.err_inject;
`else
        e3 = 1'b0;
`endif
        for (int i = 0; i < 3; i++) q3.push_back({1'b1, bus3.in_data[i], i == 0, 1'b0});
        q3.push_back({1'b1, ~^bus3.in_data ^ e3, 1'b0, 1'b1});
      end
      cur3 = q3.size() != 0 ? q3.pop_front() : 4'b0;
    end

  always @(negedge clk) begin
    chk("u8 outputs", {10'd0, bus8.ser_valid, bus8.ser_out, bus8.frame_start, bus8.frame_done, bus8.in_ready, bus8.busy, bus8.frame_cnt},
        {10'd0, cur8, q8.size() == 0, cur8[3], cnt8});
    chk("u3 outputs", {10'd0, bus3.ser_valid, bus3.ser_out, bus3.frame_start, bus3.frame_done, bus3.in_ready, bus3.busy, bus3.frame_cnt},
        {10'd0, cur3, q3.size() == 0, cur3[3], cnt3});
    if (bus8.ser_valid && bus8.frame_done) par8.push_back(bus8.ser_out);
    if (bus3.ser_valid && bus3.frame_done) par3.push_back(bus3.ser_out);
  end

  task automatic send8(input logic [7:0] d, input logic e);
    int t = 0;
    bus8.in_valid = 1'b1;
    bus8.in_data = d;
`ifdef PARITY_ERR_INJECT_EN
    bus8.err_inject = e;
`endif
    while (!bus8.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("u8 handshake timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
  endtask

  task automatic send3(input logic [2:0] d);
    int t = 0;
    bus3.in_valid = 1'b1;
    bus3.in_data = d;
    while (!bus3.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("u3 handshake timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    bus3.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input logic q[$], input int i);
    return i < q.size() ? q[i] : 1'bx;
  endfunction

  initial begin
    logic [7:0] sweep_par;
    sweep_par = 8'b0110_1001;
    bus8.in_valid = 1'b0;
    bus8.in_data = '0;
    bus3.in_valid = 1'b0;
    bus3.in_data = '0;
`ifdef PARITY_ERR_INJECT_EN
    bus8.err_inject = 1'b0;
    bus3.err_inject = 1'b0;
`endif
    idle(3);
    chk("reset outputs", {bus8.ser_valid, bus8.ser_out, bus8.frame_start, bus8.frame_done, bus8.in_ready, bus8.busy, bus8.frame_cnt},
        {6'b000010, 16'd0});
    rst = 1'b0;
    send8(8'h00, 1'b0);
    idle(12);
    chk("par 00", 32'(pick(par8, 0)), 32'd1);
    chk("cnt after 00", 32'(bus8.frame_cnt), 32'd1);
    send8(8'h07, 1'b0);
    send8(8'hFF, 1'b0);
    send8(8'h01, 1'b0);
    idle(12);
    chk("par 07", 32'(pick(par8, 1)), 32'd0);
    chk("par FF", 32'(pick(par8, 2)), 32'd1);
    chk("par 01", 32'(pick(par8, 3)), 32'd0);
    chk("cnt after b2b", 32'(bus8.frame_cnt), 32'd4);
    for (int w = 0; w < 8; w++) send3(3'(w));
    idle(6);
    for (int w = 0; w < 8; w++) chk($sformatf("w3 par %0d", w), 32'(pick(par3, w)), 32'(sweep_par[w]));
    chk("w3 cnt", 32'(bus3.frame_cnt), 32'd8);
    send8(8'hA5, 1'b0);
    idle(4);
    chk("mid frame valid", 32'(bus8.ser_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort outputs", {bus8.ser_valid, bus8.ser_out, bus8.frame_start, bus8.frame_done, bus8.in_ready, bus8.busy, bus8.frame_cnt},
        {6'b000010, 16'd0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    send8(8'h3C, 1'b0);
    idle(12);
    chk("par 3C", 32'(pick(par8, 4)), 32'd1);
    chk("cnt after abort", 32'(bus8.frame_cnt), 32'd1);
    force u8.frame_cnt = 16'hFFFF;
    cnt8 = 16'hFFFF;
    #1;
    release u8.frame_cnt;
    idle(1);
    chk("cnt preload", 32'(bus8.frame_cnt), 32'h0000FFFF);
    send8(8'h00, 1'b0);
    idle(12);
    chk("cnt wrap", 32'(bus8.frame_cnt), 32'd0);
    chk("par wrap 00", 32'(pick(par8, 5)), 32'd1);
`ifdef PARITY_ERR_INJECT_EN
    send8(8'h00, 1'b1);
    send8(8'h00, 1'b0);
    idle(12);
    chk("inject par", 32'(pick(par8, 6)), 32'd0);
    chk("clean par", 32'(pick(par8, 7)), 32'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/odd_parity_tx_ctrl.md
# odd_parity_tx_ctrl

Sequencer that accepts parallel data words over a valid/ready handshake and streams each one serially, LSB first, followed by a generated odd-parity bit. It schedules the shared odd-parity computation one bit per cycle and frames the output stream for downstream serial links. Its checker counterpart in the same subsystem consumes `ser_out`/`ser_valid`.

## Interface
- `DATA_W`, default 8: data word width in bits, ≥2.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: controller can accept a word this cycle.
- `in_data` input DATA_W: word to transmit.
- `ser_out` output 1: serial bit (data bits, then the parity bit).
- `ser_valid` output 1: `ser_out` carries a frame bit this cycle.
- `frame_start` output 1: pulses with the first data bit.
- `frame_done` output 1: pulses with the parity bit.
- `busy` output 1: a frame is in progress (state ≠ IDLE).
- `frame_cnt` output 16: count of completed frames.
- `err_inject` input 1: only present with `PARITY_ERR_INJECT_EN`.

## Operation
- Odd parity: parity bit = ~^data, so total ones over data plus parity is odd.
- FSM states:
  - IDLE: `in_ready`=1. On handshake (`in_valid`&&`in_ready`), load the shift register, init the accumulator to 1, clear the bit counter, and go to DATA.
  - DATA: shift out one bit per cycle, LSB first, XORing each bit into the accumulator. After bit DATA_W-1, go to PARITY.
  - PARITY: drive the accumulator value and set `in_ready`=1.
    - Handshake here: reload and go to DATA. Frames run back-to-back with zero gap.
    - No handshake: go to IDLE.
- While in DATA, `in_ready`=0. `in_valid` is ignored and the source must hold its word.
- `frame_cnt` increments on each PARITY cycle and wraps from 0xFFFF to 0.
- The bit counter is $clog2(DATA_W) bits wide. The DATA exit condition is counter == DATA_W-1, so non-power-of-two widths work.
- Reset mid-frame aborts the frame. No parity bit is emitted and `frame_cnt` is not incremented.

## Timing
- Reset values: `in_ready`=1 (IDLE), `ser_out`=0, `ser_valid`=0, `frame_start`=0, `frame_done`=0, `busy`=0, `frame_cnt`=0. Outputs take these values immediately on `rst` assertion.
- `ser_out`, `ser_valid`, `frame_start`, `frame_done` and `frame_cnt` are registered. `in_ready` and `busy` decode the state.
- Handshake at edge N:
  - cycle N+1: `ser_valid`=1, `ser_out`=d[0], `frame_start`=1.
  - cycles N+1 .. N+DATA_W: d[0] .. d[DATA_W-1].
  - cycle N+DATA_W+1: parity bit, `frame_done`=1, and `frame_cnt` shows the new value on the following cycle.
- Frame length is DATA_W+1 cycles. Back-to-back throughput is one word per DATA_W+1 cycles.
- First cycle after reset release: a handshake is accepted normally.

## Configuration
- Macro: `PARITY_ERR_INJECT_EN`.
- Defined:
  - `err_inject` port exists and is sampled at the handshake edge.
  - If it was 1, that frame's parity bit is inverted. Data bits are unaffected.
  - The stored flag clears when the frame ends or on reset.
- Undefined: port absent and parity is always correct. All other behaviour is identical.

## Structure
- Package `odd_parity_pkg`: FSM state enum (IDLE, DATA, PARITY), `FRAME_CNT_W`=16, and the parity reset value 1'b1.
- Sub-module `odd_parity_acc`: 1-bit accumulator with `init` and `bit_en` inputs, whose output is the running odd parity.
- Top level contains the FSM, shift register, bit counter and frame counter.

## Test plan
- Reset with DATA_W=8, send 8'h00 → `ser_out` 0,0,0,0,0,0,0,0 then parity 1. `frame_start` on bit 0, `frame_done` on the parity bit, `frame_cnt`=1.
- Send 8'h07, 8'hFF, 8'h01 back-to-back with `in_valid` held → parities 0, 1, 0. No gap cycle between frames, `in_ready`=0 during DATA.
- Build with DATA_W=3 and sweep all 8 words 000..111 → parities 1,0,0,1,0,1,1,0.
- Assert `rst` at bit 4 of a frame → all outputs return to reset values at once. The next word transmits cleanly and `frame_cnt` excludes the aborted frame.
- Preload `frame_cnt` to 0xFFFF via 65535 frames (or force), send one more → wraps to 0.
- With `PARITY_ERR_INJECT_EN`: send 8'h00 with `err_inject`=1 → parity 0. The next frame, 8'h00 with `err_inject`=0 → parity 1.
